// File: rtl/cmac_pkg.sv
// Shared constants and helpers for the CMAC int8 dot-product cell.
package cmac_pkg;
    localparam int ATOMC  = 64;
    localparam int BPE    = 8;
    localparam int PROD_W = 2 * BPE;
    localparam int SUM_W  = 2 * BPE + $clog2(ATOMC);
    localparam int PSUM_W = SUM_W - 2;
    localparam int CNT_W  = $clog2(ATOMC) + 1;
    localparam int NGRP   = 4;
    localparam int GRP    = ATOMC / NGRP;

    typedef logic signed [PROD_W-1:0] prod_t;

    // Widen both operands first so the multiply is evaluated at full product width.
    function automatic prod_t smul(input logic [BPE-1:0] a, input logic [BPE-1:0] b);
        prod_t ax;
        prod_t bx;
        ax = {{BPE{a[BPE-1]}}, a};
        bx = {{BPE{b[BPE-1]}}, b};
        return ax * bx;
    endfunction
endpackage

// File: rtl/cmac_core_mac_tree.sv
// Combinational signed reduction of N values into one sign-extended sum.
module cmac_core_mac_tree #(
    parameter int N     = 16,
    parameter int IN_W  = 16,
    parameter int OUT_W = 20
) (
    input  logic [N-1:0][IN_W-1:0] prods,
    output logic [OUT_W-1:0]       sum
);
    logic [OUT_W-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < N; i++)
            acc = acc + {{(OUT_W-IN_W){prods[i][IN_W-1]}}, prods[i]};
    end

    assign sum = acc;
endmodule

// File: rtl/cmac_core_mac_cell.sv
// Three-stage masked signed int8 dot product: multiply, 4-way partial sums, final sum.
module cmac_core_mac_cell
    import cmac_pkg::*;
(
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rst,
    input  logic [BPE*ATOMC-1:0]   dat_actv_data,
    input  logic [ATOMC-1:0]       dat_actv_nz,
    input  logic [ATOMC-1:0]       dat_actv_pvld,
    input  logic [BPE*ATOMC-1:0]   wt_actv_data,
    input  logic [ATOMC-1:0]       wt_actv_nz,
    input  logic [ATOMC-1:0]       wt_actv_pvld,
    output logic [SUM_W-1:0]       mac_out_data,
    output logic                   mac_out_pvld,
    output logic [CNT_W-1:0]       mac_out_nz_cnt
);
    logic                            vld0, vld1, vld2;
    logic [ATOMC-1:0]                en;
    logic [CNT_W-1:0]                cnt_c, cnt1, cnt2;
    logic [ATOMC-1:0][PROD_W-1:0]    prod1;
    logic [NGRP-1:0][PSUM_W-1:0]     psum_c, psum2;
    logic [SUM_W-1:0]                sum_c;

    // Only lane 0 of pvld qualifies the beat; other lanes merely gate their product.
    assign vld0 = dat_actv_pvld[0] & wt_actv_pvld[0];
    assign en   = dat_actv_pvld & wt_actv_pvld & dat_actv_nz & wt_actv_nz;

    always_comb begin
        cnt_c = '0;
        for (int k = 0; k < ATOMC; k++)
            cnt_c = cnt_c + CNT_W'(en[k]);
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            prod1 <= '0;
            cnt1  <= '0;
        end else if (vld0) begin
            for (int k = 0; k < ATOMC; k++)
                prod1[k] <= en[k] ? smul(dat_actv_data[BPE*k +: BPE], wt_actv_data[BPE*k +: BPE]) : '0;
            cnt1 <= cnt_c;
        end
    end

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        cmac_core_mac_tree #(.N(GRP), .IN_W(PROD_W), .OUT_W(PSUM_W)) u_tree (
            .prods (prod1[g*GRP +: GRP]),
            .sum   (psum_c[g])
        );
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            psum2 <= '0;
            cnt2  <= '0;
        end else if (vld1) begin
            psum2 <= psum_c;
            cnt2  <= cnt1;
        end
    end

    cmac_core_mac_tree #(.N(NGRP), .IN_W(PSUM_W), .OUT_W(SUM_W)) u_final (
        .prods (psum2),
        .sum   (sum_c)
    );

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            mac_out_data   <= '0;
            mac_out_nz_cnt <= '0;
        end else if (vld2) begin
            mac_out_data   <= sum_c;
            mac_out_nz_cnt <= cnt2;
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            vld1         <= 1'b0;
            vld2         <= 1'b0;
            mac_out_pvld <= 1'b0;
        end else begin
            vld1         <= vld0;
            vld2         <= vld1;
            mac_out_pvld <= vld2;
        end
    end
endmodule

// File: tb/tb_cmac_core_mac_cell.sv
// Scoreboard bench: stimulus pushes model results, a negedge monitor pops and compares.
module tb_cmac_core_mac_cell;
    import cmac_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [BPE*ATOMC-1:0] dat_d, wt_d;
    logic [ATOMC-1:0]     dat_nz, wt_nz, dat_pv, wt_pv;
    logic [SUM_W-1:0]     out_data;
    logic                 out_pvld;
    logic [CNT_W-1:0]     out_cnt;

    typedef struct { int data; int cnt; } exp_t;
    exp_t exp_q[$];
    logic [2:0] vhist = '0;
    int last_data = 0, last_cnt = 0;
    int checks = 0, passed = 0;

    always #5 clk = ~clk;

    cmac_core_mac_cell dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .dat_actv_data  (dat_d),
        .dat_actv_nz    (dat_nz),
        .dat_actv_pvld  (dat_pv),
        .wt_actv_data   (wt_d),
        .wt_actv_nz     (wt_nz),
        .wt_actv_pvld   (wt_pv),
        .mac_out_data   (out_data),
        .mac_out_pvld   (out_pvld),
        .mac_out_nz_cnt (out_cnt)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    // Reference: plain integer dot product over lanes where all four flags are set.
    task automatic drive(input logic [BPE*ATOMC-1:0] d, input logic [BPE*ATOMC-1:0] w,
                         input logic [ATOMC-1:0] dnz, input logic [ATOMC-1:0] wnz,
                         input logic [ATOMC-1:0] dpv, input logic [ATOMC-1:0] wpv);
        exp_t e;
        logic v;
        dat_d = d; wt_d = w; dat_nz = dnz; wt_nz = wnz; dat_pv = dpv; wt_pv = wpv;
        v = dpv[0] && wpv[0];
        if (v) begin
            e.data = 0; e.cnt = 0;
            for (int k = 0; k < ATOMC; k++) begin
                if (dpv[k] && wpv[k] && dnz[k] && wnz[k]) begin
                    byte signed a, b;
                    a = d[BPE*k +: BPE];
                    b = w[BPE*k +: BPE];
                    e.data += int'(a) * int'(b);
                    e.cnt++;
                end
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        vhist = {vhist[1:0], v};
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0, '0, '0, '0, '0);
    endtask

    task automatic fill(input logic [7:0] dv, input logic [7:0] wv,
                        output logic [BPE*ATOMC-1:0] d, output logic [BPE*ATOMC-1:0] w);
        for (int k = 0; k < ATOMC; k++) begin
            d[BPE*k +: BPE] = dv;
            w[BPE*k +: BPE] = wv;
        end
    endtask

    task automatic rand_beat(input bit bubble);
        logic [BPE*ATOMC-1:0] d, w;
        logic [ATOMC-1:0] dnz, wnz, dpv, wpv;
        for (int k = 0; k < ATOMC; k++) begin
            d[BPE*k +: BPE] = 8'($urandom);
            w[BPE*k +: BPE] = 8'($urandom);
            dnz[k] = ($urandom_range(3) != 0);
            wnz[k] = ($urandom_range(3) != 0);
            dpv[k] = ($urandom_range(7) != 0);
            wpv[k] = ($urandom_range(7) != 0);
        end
        dpv[0] = !bubble;
        wpv[0] = 1'b1;
        drive(d, w, dnz, wnz, dpv, wpv);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        exp_q.delete();
        vhist = '0;
        last_data = 0;
        last_cnt = 0;
        #1;
        check("rst_data", int'($signed(out_data)), 0);
        check("rst_cnt", int'(out_cnt), 0);
        check("rst_pvld", int'(out_pvld), 0);
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: pvld must follow the input beat pattern; outputs hold during gaps.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check("pvld", int'(out_pvld), int'(vhist[2]));
            if (out_pvld) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("data", int'($signed(out_data)), e.data);
                    check("nz_cnt", int'(out_cnt), e.cnt);
                    last_data = e.data;
                    last_cnt = e.cnt;
                end
            end else begin
                check("hold_data", int'($signed(out_data)), last_data);
                check("hold_cnt", int'(out_cnt), last_cnt);
            end
        end
    end

    initial begin
        logic [BPE*ATOMC-1:0] d, w;
        logic [ATOMC-1:0] ones, wnz;
        ones = '1;
        dat_d = '0; wt_d = '0; dat_nz = '0; wt_nz = '0; dat_pv = '0; wt_pv = '0;
        #2;
        do_reset(2);
        idle(2);

        fill(8'd1, 8'd1, d, w);
        drive(d, w, ones, ones, ones, ones);
        idle(5);

        fill(8'h80, 8'h80, d, w);
        drive(d, w, ones, ones, ones, ones);
        fill(8'h80, 8'h7f, d, w);
        drive(d, w, ones, ones, ones, ones);
        idle(4);

        fill(8'd5, 8'd3, d, w);
        wnz = ones;
        wnz[3] = 1'b0;
        drive(d, w, 64'h3FF, wnz, ones, ones);
        // Beat with no contributing lanes still produces a pulse with zero result.
        drive(d, w, '0, '0, ones, ones);
        idle(4);

        for (int i = 0; i < 23; i++) rand_beat(i == 4 || i == 11 || i == 17);
        idle(4);

        fill(8'd7, 8'd9, d, w);
        for (int i = 0; i < 4; i++) drive(d, w, ones, ones, ones, '0);
        idle(4);

        rand_beat(1'b0);
        rand_beat(1'b0);
        do_reset(1);
        idle(4);
        fill(8'hfe, 8'd3, d, w);
        drive(d, w, ones, ones, ones, ones);
        idle(5);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
